// File: rtl/gen_requests_kn.sv
// K-channel request generator for shared-memory arbitration tests: each channel is
// paced by its own LFSR and issues sequential or pseudo-random requests over valid/ready.
module gen_requests_kn #(
    parameter int          K      = 4,
    parameter int          ADDR_W = 8,
    parameter int          DATA_W = 16,
    parameter int          CNT_W  = 12,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [3:0]            rate,
    input  logic [CNT_W-1:0]      num_req,
    output logic [K-1:0]          req_valid,
    input  logic [K-1:0]          req_ready,
    output logic [K-1:0]          req_we,
    output logic [K*ADDR_W-1:0]   req_addr,
    output logic [K*DATA_W-1:0]   req_wdata,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               mode_reg;
    logic [3:0]         rate_reg;
    logic [CNT_W-1:0]   num_reg;

    logic               launch;
    logic [K-1:0]       chan_idle;
    logic               all_idle;

    // A start seen in RUN must not disturb the channels, so launch is gated by state.
    assign launch   = start && (state_reg != RUN);
    assign all_idle = &chan_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            mode_reg  <= 1'b0;
            rate_reg  <= '0;
            num_reg   <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (all_idle) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        state_reg <= RUN;
                        busy_reg  <= 1'b1;
                        done_reg  <= 1'b0;
                        mode_reg  <= mode;
                        rate_reg  <= rate;
                        num_reg   <= num_req;
                    end
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;

    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_chan
            localparam logic [15:0] SEED_MIX = SEED ^ 16'(gi * 16'h1F3D);
            localparam logic [15:0] SEED_CH  = (SEED_MIX == 16'h0000) ? 16'h0001 : SEED_MIX;
            localparam logic [ADDR_W-1:0] BASE = ADDR_W'(gi) << (ADDR_W - 2);

            logic               valid_reg;
            logic               we_reg;
            logic [ADDR_W-1:0]  addr_reg;
            logic [DATA_W-1:0]  wdata_reg;
            logic [CNT_W-1:0]   issued_reg;
            logic [15:0]        lfsr_reg;

            logic [15:0]        lfsr_next;
            logic               issue;
            logic               we_next;
            logic [ADDR_W-1:0]  addr_next;
            logic [DATA_W-1:0]  wdata_next;
            logic [ADDR_W-1:0]  rnd_addr;

            // Fibonacci LFSR, taps 16,14,13,11 in right-shift form.
            assign lfsr_next = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5],
                                lfsr_reg[15:1]};

            if (ADDR_W > 16) begin : g_wide_addr
                assign rnd_addr = ADDR_W'(lfsr_reg);
            end else begin : g_narrow_addr
                assign rnd_addr = lfsr_reg[ADDR_W-1:0];
            end

            assign issue = (issued_reg < num_reg) && (lfsr_reg[3:0] <= rate_reg);

            always_comb begin
                wdata_next                   = '0;
                wdata_next[DATA_W-1 -: 4]    = 4'(gi);
                wdata_next[CNT_W-1:0]        = issued_reg;
                if (mode_reg) begin
                    we_next   = lfsr_reg[4];
                    addr_next = rnd_addr;
                end else begin
                    // Pairs of write-then-read share one address.
                    we_next   = ~issued_reg[0];
                    addr_next = BASE + ADDR_W'(issued_reg >> 1);
                end
            end

            assign chan_idle[gi] = !valid_reg && (issued_reg == num_reg);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg  <= 1'b0;
                    we_reg     <= 1'b0;
                    addr_reg   <= '0;
                    wdata_reg  <= '0;
                    issued_reg <= '0;
                    lfsr_reg   <= SEED_CH;
                end else if (launch) begin
                    valid_reg  <= 1'b0;
                    we_reg     <= 1'b0;
                    addr_reg   <= '0;
                    wdata_reg  <= '0;
                    issued_reg <= '0;
                end else if (state_reg == RUN) begin
                    if (valid_reg) begin
                        if (req_ready[gi]) begin
                            valid_reg  <= 1'b0;
                            issued_reg <= issued_reg + 1'b1;
                        end
                    end else begin
                        lfsr_reg <= lfsr_next;
                        if (issue) begin
                            valid_reg <= 1'b1;
                            we_reg    <= we_next;
                            addr_reg  <= addr_next;
                            wdata_reg <= wdata_next;
                        end
                    end
                end
            end

            assign req_valid[gi]                   = valid_reg;
            assign req_we[gi]                      = we_reg;
            assign req_addr[gi*ADDR_W +: ADDR_W]   = addr_reg;
            assign req_wdata[gi*DATA_W +: DATA_W]  = wdata_reg;
        end
    endgenerate

endmodule

// File: tb/tb_gen_requests_kn.sv
// Scoreboard bench for gen_requests_kn: expected requests come from a request-list model,
// a negedge monitor pops and compares on every valid&ready transfer.
module tb_gen_requests_kn;
    localparam int          K      = 4;
    localparam int          ADDR_W = 8;
    localparam int          DATA_W = 16;
    localparam int          CNT_W  = 12;
    localparam logic [15:0] SEED   = 16'hACE1;
    localparam int          EW     = 1 + ADDR_W + DATA_W;
    localparam int          BUDGET = 8000;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic               start     = 1'b0;
    logic               mode      = 1'b0;
    logic [3:0]         rate      = 4'h0;
    logic [CNT_W-1:0]   num_req   = '0;
    logic [K-1:0]       req_ready = '0;
    logic [K-1:0]       req_valid;
    logic [K-1:0]       req_we;
    logic [K*ADDR_W-1:0] req_addr;
    logic [K*DATA_W-1:0] req_wdata;
    logic               busy;
    logic               done;

    gen_requests_kn #(
        .K(K), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .rate(rate),
        .num_req(num_req), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [EW-1:0] exp_q [K][$];
    int acc_cnt [K];
    int stall0;
    int sample_n = 0;
    int last_acc_sample, first_busy_sample, first_valid_sample, done_sample, busy_samples;
    bit mon_en = 1'b0;
    int ready_mode = 0;
    int bp_cnt = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [EW-1:0] payload(input int i);
        return {req_we[i], req_addr[i*ADDR_W +: ADDR_W], req_wdata[i*DATA_W +: DATA_W]};
    endfunction

    function automatic logic [EW-1:0] mk(input logic we, input logic [ADDR_W-1:0] addr,
                                         input int i, input int j);
        logic [DATA_W-1:0] wd;
        wd = DATA_W'((i & 15) << (DATA_W - 4)) | DATA_W'(j);
        return {we, addr, wd};
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        int   taps [4];
        logic fb;
        taps = '{16, 14, 13, 11};
        fb = 1'b0;
        for (int t = 0; t < 4; t++) fb ^= s[16 - taps[t]];
        return {fb, s[15:1]};
    endfunction

    function automatic logic [15:0] chan_seed(input int i);
        logic [15:0] s;
        s = SEED ^ 16'(i * 16'h1F3D);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    // Expected request list per channel. Random runs are only started straight
    // after reset, so every LFSR begins at its channel seed.
    task automatic load_expected(input bit m, input logic [3:0] r, input int n);
        for (int i = 0; i < K; i++) begin
            logic [15:0] s;
            int j;
            exp_q[i].delete();
            s = chan_seed(i);
            j = 0;
            while (j < n) begin
                if (m) begin
                    if (s[3:0] <= r) begin
                        exp_q[i].push_back(mk(s[4], s[ADDR_W-1:0], i, j));
                        j++;
                    end
                    s = lfsr_step(s);
                end else begin
                    exp_q[i].push_back(mk(~j[0], ADDR_W'((i << (ADDR_W - 2)) + (j >> 1)), i, j));
                    j++;
                end
            end
        end
    endtask

    // Ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: req_ready = '1;
                1: req_ready = K'($urandom);
                2: begin
                    req_ready    = '1;
                    req_ready[0] = (bp_cnt >= 10);
                    if (req_valid[0] && bp_cnt < 10) bp_cnt++;
                end
                3: begin
                    req_ready    = '1;
                    req_ready[2] = 1'b0;
                end
                default: req_ready = '0;
            endcase
        end
    end

    // Monitor
    initial begin
        logic [EW-1:0] prev_pl [K];
        bit prev_v [K];
        bit prev_r [K];
        forever begin
            @(negedge clk);
            sample_n++;
            if (!mon_en) begin
                for (int i = 0; i < K; i++) begin
                    prev_v[i] = 1'b0;
                    prev_r[i] = 1'b0;
                end
            end else begin
                if (busy) begin
                    busy_samples++;
                    if (first_busy_sample < 0) first_busy_sample = sample_n;
                end
                if (done && done_sample < 0) done_sample = sample_n;
                if (|req_valid && first_valid_sample < 0) first_valid_sample = sample_n;
                for (int i = 0; i < K; i++) begin
                    if (prev_v[i] && !prev_r[i]) begin
                        check($sformatf("hold_valid_ch%0d", i), req_valid[i], 1);
                        check($sformatf("hold_payload_ch%0d", i), payload(i), prev_pl[i]);
                    end
                    if (prev_v[i] && prev_r[i])
                        check($sformatf("gap_after_accept_ch%0d", i), req_valid[i], 0);
                    if (req_valid[i])
                        check($sformatf("valid_only_when_busy_ch%0d", i), busy, 1);
                    if (i == 0 && req_valid[i] && !req_ready[i]) stall0++;
                    if (req_valid[i] && req_ready[i]) begin
                        acc_cnt[i]++;
                        last_acc_sample = sample_n;
                        if (exp_q[i].size() == 0)
                            check($sformatf("unexpected_xfer_ch%0d", i), 0, 1);
                        else
                            check($sformatf("xfer_ch%0d", i), payload(i), exp_q[i].pop_front());
                    end
                    prev_v[i]  = req_valid[i];
                    prev_r[i]  = req_ready[i];
                    prev_pl[i] = payload(i);
                end
            end
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_valid", req_valid, 0);
        check("rst_we", req_we, 0);
        check("rst_addr", req_addr, 0);
        check("rst_wdata", req_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);
        check("post_rst_valid", req_valid, 0);
        for (int i = 0; i < K; i++) exp_q[i].delete();
    endtask

    task automatic run(input bit m, input logic [3:0] r, input int n, input int rmode, input bit poke);
        int cyc;
        int total;
        load_expected(m, r, n);
        for (int i = 0; i < K; i++) acc_cnt[i] = 0;
        stall0     = 0;
        bp_cnt     = 0;
        ready_mode = rmode;
        mon_en     = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b1;
        mode    = m;
        rate    = r;
        num_req = CNT_W'(n);
        @(posedge clk);
        #1;
        // Scramble the config inputs to show they were sampled at start.
        start   = 1'b0;
        mode    = ~m;
        rate    = ~r;
        num_req = CNT_W'(n + 1);
        busy_samples       = 0;
        first_busy_sample  = -1;
        first_valid_sample = -1;
        done_sample        = -1;
        last_acc_sample    = -1;
        check("busy_after_start", busy, 1);
        check("done_after_start", done, 0);
        if (poke) begin
            repeat (2) @(posedge clk);
            #1;
            start   = 1'b1;
            num_req = CNT_W'(1);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        cyc = 0;
        while (!done && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check("run_completes", done, 1);
        @(negedge clk);
        total = 0;
        for (int i = 0; i < K; i++) begin
            total += acc_cnt[i];
            check($sformatf("count_ch%0d", i), acc_cnt[i], n);
            check($sformatf("queue_empty_ch%0d", i), exp_q[i].size(), 0);
        end
        check("total_transfers", total, K * n);
        if (n > 0)
            check("done_latency", done_sample - last_acc_sample, 2);
        else
            check("busy_cycles_zero_req", busy_samples, 1);
        if (r == 4'hF && n > 0)
            check("first_valid_latency", first_valid_sample - first_busy_sample, 1);
        if (rmode == 2)
            check("bp_stall_cycles", stall0, 10);
        $display("[TB] run mode=%0d rate=%0d num_req=%0d ready_mode=%0d transfers=%0d",
                 m, r, n, rmode, total);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        do_reset();
        run(1'b1, 4'h0, 100, 0, 1'b0);
        do_reset();
        run(1'b1, 4'($urandom_range(1, 14)), 30, 1, 1'b0);
        run(1'b0, 4'hF, 4, 0, 1'b0);
        run(1'b0, 4'($urandom_range(3, 15)), 2, 2, 1'b0);
        run(1'b0, 4'hF, 0, 0, 1'b0);
        run(1'b0, 4'hF, 3, 0, 1'b1);
        run(1'b0, 4'hF, 2, 0, 1'b0);
        run(1'b0, 4'h7, 6, 1, 1'b0);
        run(1'b0, 4'hF, 140, 0, 1'b0);

        // Reset in the middle of a run while channel 2 is stalled with valid high.
        load_expected(1'b0, 4'hF, 50);
        ready_mode = 3;
        mon_en     = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b1;
        mode    = 1'b0;
        rate    = 4'hF;
        num_req = CNT_W'(50);
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (!req_valid[2] && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("ch2_valid_before_reset", req_valid[2], 1);
        do_reset();
        run(1'b0, 4'hF, 2, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gen_requests_kn.md
Name: gen_requests_kn

Overview:
- Parametrised multi-client request generator for shared-memory arbitration tests.
- Drives K independent request channels with valid/ready handshakes toward the arbiter/memory under test.
- Channels run in sequential or pseudo-random mode, with programmable issue rate and request count.
- Successor to the port-less fixed generator: adds widths, channel count, modes, back-pressure handling and completion status.

Parameters:
- K, 4, number of client channels (1..16).
- ADDR_W, 8, address width per channel.
- DATA_W, 16, write-data width per channel; must be >= 4 + CNT_W.
- CNT_W, 12, width of the per-channel request counter and of num_req.
- SEED, 16'hACE1, base LFSR seed; channel i seed = SEED ^ (i*16'h1F3D), forced to 16'h0001 if the result is zero.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle start pulse; honoured only in IDLE or DONE.
- mode  in  1  0 = sequential, 1 = random; sampled at start.
- rate  in  4  issue threshold; sampled at start.
- num_req  in  CNT_W  requests per channel; sampled at start.
- req_valid  out  K  per-channel request valid.
- req_ready  in  K  per-channel accept from the arbiter.
- req_we  out  K  1 = write, 0 = read.
- req_addr  out  K*ADDR_W  channel i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  out  K*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- busy  out  1  high in RUN.
- done  out  1  high in DONE until the next start.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. All outputs are 0. Counters, addresses and the sampled config are cleared. Each LFSR is reloaded with its channel seed.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE in the cycle after every channel has issued == num_req with req_valid low.
  - DONE -> RUN on start, which re-samples the config and clears counters. LFSRs are not reseeded.
- start while in RUN is ignored.
- num_req == 0: RUN lasts exactly 1 cycle with no valids asserted, then DONE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, one per channel. It advances every RUN cycle in which that channel's req_valid is low.
- Issue decision, per channel per RUN cycle:
  - Conditions: valid is low, issued < num_req, and lfsr[3:0] <= rate.
  - When met, req_valid is registered high on the next edge.
  - rate = 4'hF issues every eligible cycle. rate = 0 issues with probability 1/16.
- First possible valid: the second rising edge after the start edge, i.e. a latency of 1 cycle after entering RUN.
- Handshake:
  - A transfer occurs when req_valid and req_ready are both high at a rising edge.
  - While valid is high and not accepted, req_we, req_addr and req_wdata hold stable.
  - Valid is never withdrawn without acceptance.
  - After acceptance, valid deasserts for at least 1 cycle. No back-to-back issue on one channel.
  - issued increments on acceptance.
- Sequential mode:
  - Requests alternate write then read to the same address.
  - Request j uses addr = (i<<(ADDR_W-2)) + (j>>1), wrapping mod 2^ADDR_W, and we = ~j[0].
- Random mode: addr = lfsr[ADDR_W-1:0] (zero-extended if ADDR_W > 16); we = lfsr[4].
- wdata = {i[3:0], zeros, issued[CNT_W-1:0]}. It is valid in both modes and is don't-care-stable on reads.
- Concurrency: channels are fully independent. Any subset of channels may be valid simultaneously, and ready on a non-valid channel is ignored.
- Counter wrap: issued never exceeds num_req, so wrap is impossible.
- Reset mid-handshake: valid drops immediately, and no transfer is counted.

Test Plan:
- Reset mid-RUN with channel 2 valid: rst_n low for 3 cycles -> all outputs 0 asynchronously; after release, FSM is in IDLE and done = 0.
- K=4, mode=0, rate=F, num_req=4, req_ready all 1 -> channel 1 issues W 0x40, R 0x40, W 0x41, R 0x41 (ADDR_W=8). Valid is high every other cycle. done rises 1 cycle after the last accept. Total accepts = 16.
- Back-pressure: channel 0 ready held 0 for 10 cycles then 1 -> valid, addr and wdata stable for all 10 cycles; exactly one transfer counted.
- mode=1, rate=0, num_req=100, ready=1 -> each channel completes exactly 100 transfers, and the LFSR sequence matches the reference model from its seed.
- num_req=0 -> busy high for 1 cycle, no valid, then done; start pulsed during RUN of a second run is ignored.
- DONE then start with num_req=2 -> counters restart, done drops the cycle after start, and 8 transfers complete.
